// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if
// Control inputs and BCD display outputs of the stopwatch counting core.
// The master side drives the tick and button pulses and observes the
// display. The slave side is the counter itself.

interface stopwatch_counter_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       running;
  logic       overflow;
  logic       lap_active;

  modport master (
    output tick_in, start_stop, clear, lap,
    input  digit0, digit1, digit2, digit3, running, overflow, lap_active
  );

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output digit0, digit1, digit2, digit3, running, overflow, lap_active
  );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
// BCD M:SS.T time-keeping core. It synchronises the 0.1 s square wave from
// the clock divider and turns each rising edge into a single-cycle count
// enable. It then advances a cascaded BCD count under start/stop/clear
// control, and saturates at MAX_MIN:59.9 with a sticky overflow flag.
//
// Optional feature macro: LAP_HOLD_EN
//   When defined, a lap pulse while running freezes the display on a
//   snapshot of the count. The live count keeps advancing underneath.
//   When undefined, lap is ignored and lap_active is tied low.
//
// SYNC_STAGES must be at least 2.

module stopwatch_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 9
) (
  input  logic               clockin,
  input  logic               reset,
  stopwatch_counter_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [3:0] MaxMin = 4'(MAX_MIN);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;
  logic                   tick;

  logic [3:0] cnt0_q, cnt1_q, cnt2_q, cnt3_q;
  logic [3:0] cnt0_d, cnt1_d, cnt2_d, cnt3_d;
  logic       running_q;
  logic       overflow_q;
  logic       at_full;

  // Bring tick_in into the clockin domain and keep one extra delayed copy for edge detection
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw.tick_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~delay_q;

  assign at_full = (cnt3_q == MaxMin) && (cnt2_q == 4'd5) &&
                   (cnt1_q == 4'd9) && (cnt0_q == 4'd9);

  // Incremented BCD count with the tenths -> seconds -> tens -> minutes carry chain
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    cnt3_d = cnt3_q;
    if (cnt0_q == 4'd9) begin
      cnt0_d = 4'd0;
      if (cnt1_q == 4'd9) begin
        cnt1_d = 4'd0;
        if (cnt2_q == 4'd5) begin
          cnt2_d = 4'd0;
          cnt3_d = cnt3_q + 4'd1;
        end else begin
          cnt2_d = cnt2_q + 4'd1;
        end
      end else begin
        cnt1_d = cnt1_q + 4'd1;
      end
    end else begin
      cnt0_d = cnt0_q + 4'd1;
    end
  end

  // Run/stop/clear control, live count, saturation and the sticky overflow flag
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt0_q     <= 4'd0;
      cnt1_q     <= 4'd0;
      cnt2_q     <= 4'd0;
      cnt3_q     <= 4'd0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (at_full) begin
              overflow_q <= 1'b1;
              state_q    <= STOP;
              running_q  <= 1'b0;
            end else begin
              cnt0_q <= cnt0_d;
              cnt1_q <= cnt1_d;
              cnt2_q <= cnt2_d;
              cnt3_q <= cnt3_d;
            end
          end
          if (sw.start_stop) begin
            state_q   <= STOP;
            running_q <= 1'b0;
          end
        end
        IDLE, STOP: begin
          if (sw.clear) begin
            state_q    <= IDLE;
            cnt0_q     <= 4'd0;
            cnt1_q     <= 4'd0;
            cnt2_q     <= 4'd0;
            cnt3_q     <= 4'd0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
          end else if (sw.start_stop && !overflow_q) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw.running  = running_q;
  assign sw.overflow = overflow_q;

`ifdef LAP_HOLD_EN
  logic       lap_active_q;
  logic [3:0] snap0_q, snap1_q, snap2_q, snap3_q;

  // Lap freeze: a snapshot is taken on the first lap pulse and released on the next; leaving RUN always releases it
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      lap_active_q <= 1'b0;
      snap0_q      <= 4'd0;
      snap1_q      <= 4'd0;
      snap2_q      <= 4'd0;
      snap3_q      <= 4'd0;
    end else if (state_q == RUN) begin
      if (sw.start_stop || (tick && at_full)) begin
        lap_active_q <= 1'b0;
      end else if (sw.lap) begin
        if (!lap_active_q) begin
          snap0_q      <= cnt0_q;
          snap1_q      <= cnt1_q;
          snap2_q      <= cnt2_q;
          snap3_q      <= cnt3_q;
          lap_active_q <= 1'b1;
        end else begin
          lap_active_q <= 1'b0;
        end
      end
    end else begin
      lap_active_q <= 1'b0;
    end
  end

  assign sw.lap_active = lap_active_q;
  assign sw.digit0     = lap_active_q ? snap0_q : cnt0_q;
  assign sw.digit1     = lap_active_q ? snap1_q : cnt1_q;
  assign sw.digit2     = lap_active_q ? snap2_q : cnt2_q;
  assign sw.digit3     = lap_active_q ? snap3_q : cnt3_q;
`else
  logic unused_lap;
  assign unused_lap    = sw.lap;
  assign sw.lap_active = 1'b0;
  assign sw.digit0     = cnt0_q;
  assign sw.digit1     = cnt1_q;
  assign sw.digit2     = cnt2_q;
  assign sw.digit3     = cnt3_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter
// Scoreboard bench for stopwatch_counter. The driver issues directed and
// random operations, and pushes the expected display into a queue. That
// expectation comes from a model that keeps the elapsed time as a plain
// count of tenths. A separate monitor pops and compares on the falling edge.

module tb_stopwatch_counter;

  localparam int MaxMin    = 9;
  localparam int FullScale = MaxMin * 600 + 599;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       run;
    logic       ovf;
    logic       lap;
  } view_t;

  logic clockin = 1'b0;
  logic reset   = 1'b1;

  stopwatch_counter_if swIf ();

  stopwatch_counter #(
    .SYNC_STAGES (2),
    .MAX_MIN     (MaxMin)
  ) dut (
    .clockin (clockin),
    .reset   (reset),
    .sw      (swIf)
  );

  // 100 MHz system clock
  always #5 clockin = ~clockin;

  view_t expQ[$];
  int    compared   = 0;
  int    mismatched = 0;

  // Reference model: elapsed time in tenths plus run/overflow/lap flags
  int mTenths    = 0;
  int mLapTenths = 0;
  bit mRun       = 1'b0;
  bit mOvf       = 1'b0;
  bit mLap       = 1'b0;

  function automatic view_t modelView();
    view_t v;
    int    t;
    t    = mLap ? mLapTenths : mTenths;
    v.d0 = 4'(t % 10);
    v.d1 = 4'((t / 10) % 10);
    v.d2 = 4'((t / 100) % 6);
    v.d3 = 4'(t / 600);
    v.run = mRun;
    v.ovf = mOvf;
    v.lap = mLap;
    return v;
  endfunction

  task automatic modelTick();
    if (mRun) begin
      if (mTenths == FullScale) begin
        mOvf = 1'b1;
        mRun = 1'b0;
        mLap = 1'b0;
      end else begin
        mTenths = mTenths + 1;
      end
    end
  endtask

  task automatic modelStartStop();
    if (mRun) begin
      mRun = 1'b0;
      mLap = 1'b0;
    end else if (!mOvf) begin
      mRun = 1'b1;
    end
  endtask

  task automatic modelClear();
    if (!mRun) begin
      mTenths = 0;
      mOvf    = 1'b0;
      mLap    = 1'b0;
    end
  endtask

  task automatic modelLap();
`ifdef LAP_HOLD_EN
    if (mRun) begin
      if (!mLap) begin
        mLapTenths = mTenths;
        mLap       = 1'b1;
      end else begin
        mLap = 1'b0;
      end
    end
`endif
  endtask

  task automatic modelReset();
    mTenths    = 0;
    mLapTenths = 0;
    mRun       = 1'b0;
    mOvf       = 1'b0;
    mLap       = 1'b0;
  endtask

  // Compare the DUT display with one expected view
  task automatic checkOutput(input view_t exp);
    view_t act;
    act.d3  = swIf.digit3;
    act.d2  = swIf.digit2;
    act.d1  = swIf.digit1;
    act.d0  = swIf.digit0;
    act.run = swIf.running;
    act.ovf = swIf.overflow;
    act.lap = swIf.lap_active;
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL display: got %0h:%0h%0h.%0h run=%0b ovf=%0b lap=%0b, expected %0h:%0h%0h.%0h run=%0b ovf=%0b lap=%0b",
               act.d3, act.d2, act.d1, act.d0, act.run, act.ovf, act.lap,
               exp.d3, exp.d2, exp.d1, exp.d0, exp.run, exp.ovf, exp.lap);
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge
  always @(negedge clockin) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic expectNow();
    @(posedge clockin);
    #1;
    expQ.push_back(modelView());
  endtask

  task automatic pulseStartStop();
    @(negedge clockin);
    swIf.start_stop = 1'b1;
    @(negedge clockin);
    swIf.start_stop = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clockin);
    swIf.clear = 1'b1;
    @(negedge clockin);
    swIf.clear = 1'b0;
  endtask

  task automatic pulseLap();
    @(negedge clockin);
    swIf.lap = 1'b1;
    @(negedge clockin);
    swIf.lap = 1'b0;
  endtask

  task automatic tickBurst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clockin);
      swIf.tick_in = 1'b1;
      @(negedge clockin);
      swIf.tick_in = 1'b0;
      modelTick();
    end
    repeat (3) @(negedge clockin);
  endtask

  // The tick enable is high between the 2nd and 3rd edges after tick_in rises; start_stop lands in that window
  task automatic tickWithStop();
    @(negedge clockin);
    swIf.tick_in = 1'b1;
    @(negedge clockin);
    swIf.tick_in = 1'b0;
    @(negedge clockin);
    swIf.start_stop = 1'b1;
    @(negedge clockin);
    swIf.start_stop = 1'b0;
    modelTick();
    modelStartStop();
    repeat (2) @(negedge clockin);
  endtask

  task automatic resetPulse();
    @(negedge clockin);
    #1;
    reset = 1'b1;
    modelReset();
    #1;
    expQ.push_back(modelView());
    @(negedge clockin);
    reset = 1'b0;
  endtask

  // op: 0 ticks, 1 start_stop, 2 clear, 3 lap, 4 tick+start_stop, 5 reset
  task automatic applyStimulus(input int op, input int n);
    case (op)
      0: tickBurst(n);
      1: begin pulseStartStop(); modelStartStop(); end
      2: begin pulseClear(); modelClear(); end
      3: begin pulseLap(); modelLap(); end
      4: tickWithStop();
      default: ;
    endcase
    if (op == 5) resetPulse();
    else expectNow();
  endtask

  initial begin
    int r;
    swIf.tick_in    = 1'b0;
    swIf.start_stop = 1'b0;
    swIf.clear      = 1'b0;
    swIf.lap        = 1'b0;
    modelReset();
    repeat (2) @(negedge clockin);
    #1;
    expQ.push_back(modelView());
    @(negedge clockin);
    reset = 1'b0;

    // Start and count one second
    applyStimulus(1, 0);
    applyStimulus(0, 10);
    // Carries into minutes and into seconds tens
    applyStimulus(0, 589);
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 99);
    applyStimulus(0, 1);
    // Saturation at full scale, sticky overflow, and recovery by clear
    applyStimulus(0, FullScale - 100);
    applyStimulus(0, 1);
    applyStimulus(1, 0);
    applyStimulus(0, 3);
    applyStimulus(2, 0);
    // A tick in the same cycle as stop is still counted
    applyStimulus(1, 0);
    applyStimulus(0, 4);
    applyStimulus(4, 0);
    applyStimulus(0, 5);
    // Clear while running is ignored; reset mid-run
    applyStimulus(2, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 32);
    applyStimulus(2, 0);
    applyStimulus(5, 0);
    // Lap freeze and release
    applyStimulus(1, 0);
    applyStimulus(0, 20);
    applyStimulus(3, 0);
    applyStimulus(0, 30);
    applyStimulus(3, 0);
    applyStimulus(3, 0);
    applyStimulus(1, 0);

    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 19));
      if (r <= 7)       applyStimulus(0, int'($urandom_range(1, 30)));
      else if (r <= 10) applyStimulus(1, 0);
      else if (r <= 12) applyStimulus(2, 0);
      else if (r <= 15) applyStimulus(3, 0);
      else if (r <= 17) applyStimulus(4, 0);
      else if (r == 18) applyStimulus(5, 0);
      else              applyStimulus(0, int'($urandom_range(50, 300)));
    end

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clockin);
    if (expQ.size() > 0) begin
      compared   = compared + 1;
      mismatched = mismatched + 1;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
